// File: rtl/counter_run_ctrl.sv
// Run controller for the count register: start, count to a latched
// target, then stop or auto-reload, with hold, abort and a done pulse.
module counter_run_ctrl #(
   parameter int WIDTH    = 4,
   parameter int PRESCALE = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic             hold,
   input  logic [WIDTH-1:0] target,
   input  logic             auto_reload,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             done
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] tgt_q, tgt_d;
   logic             ar_q, ar_d;
   logic             done_q, done_d;
   logic [PW-1:0]    pre_q, pre_d;
   logic             tick;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         count_q <= '0;
         tgt_q   <= '0;
         ar_q    <= 1'b0;
         done_q  <= 1'b0;
         pre_q   <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         tgt_q   <= tgt_d;
         ar_q    <= ar_d;
         done_q  <= done_d;
         pre_q   <= pre_d;
      end
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      tgt_d   = tgt_q;
      ar_d    = ar_q;
      done_d  = 1'b0;
      pre_d   = pre_q;
      tick    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               count_d = '0;
               if (target != '0) begin
                  tgt_d   = target;
                  ar_d    = auto_reload;
                  pre_d   = '0;
                  state_d = RUN;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         RUN: begin
            // stop wins over a coincident tick
            if (stop) begin
               state_d = IDLE;
            end else if (!hold) begin
               if (pre_q == PRE_MAX) begin
                  pre_d = '0;
                  tick  = 1'b1;
               end else begin
                  pre_d = pre_q + PW'(1);
               end
            end
            if (tick) begin
               if (count_q == tgt_q) begin
                  count_d = '0;
               end else if (count_q == tgt_q - WIDTH'(1)) begin
                  count_d = tgt_q;
                  done_d  = 1'b1;
                  if (!ar_q) state_d = IDLE;
               end else begin
                  count_d = count_q + WIDTH'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign count = count_q;
   assign busy  = (state_q == RUN);
   assign done  = done_q;

endmodule
